// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EXU issue logic and the multi-cycle
// RV64M sequencer.
//
// Signals:
//   in_valid  : request present            (master -> slave)
//   in_ready  : request can be accepted    (slave  -> master)
//   op        : one-hot {remu, rem, divu, div, mul}, same order as alu_op[16:12]
//   word      : 32-bit "w" variant (inst_32bit)
//   src1      : rs1 operand / dividend
//   src2      : rs2 operand / divisor
//   flush     : abort the current operation (trap/redirect)
//   out_valid : result available           (slave  -> master)
//   out_ready : consumer takes result      (master -> slave)
//   result    : final result               (slave  -> master)
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 64
) ();

    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic             word;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for the RV64M ops mul, div, divu, rem, remu and their
// 32-bit "w" forms. Sits beside the single-cycle ALU and stalls the pipeline
// through a valid/ready handshake while it iterates one bit per cycle
// (shift-add multiply, restoring divide). Divide-by-zero, signed overflow and
// malformed op codes take a one-cycle special path.
//
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : muldiv_seq_if.slave (request, flush, response handshake)
//
// Latency from the accept edge to out_valid: N+1 cycles with N = 64, or 32 for
// word ops; special cases take 1 cycle. The divide fix-up (sign correction) is
// folded into the final iteration.
//
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiplier
// with a single-cycle combinational one (mul goes straight IDLE -> DONE and the
// MUL state is not built). Divide behaviour is the same in both builds.
//
// Only WIDTH = 64 is supported.
module muldiv_seq #(
    parameter int unsigned WIDTH = 64
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);

    // Most negative value, full width and sign-extended 32-bit form.
    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MinNegW = {{(WIDTH-31){1'b1}}, 31'b0};

    typedef enum logic [1:0] {
        StIdle,
`ifndef MULDIV_FAST_MUL_EN
        StMul,
`endif
        StDiv,
        StDone
    } state_e;

    // Word results are always the sign extension of the low 32 bits.
    function automatic logic [WIDTH-1:0] fmt_res(input logic w, input logic [WIDTH-1:0] v);
        fmt_res = w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // mul accumulator / div remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;     // mul multiplicand / div divisor
    logic [WIDTH-1:0] quo_q, quo_d;     // mul multiplier / div dividend->quotient
    logic             word_q, word_d;
    logic             rem_sel_q, rem_sel_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Request decode and operand preparation
    logic             op_mul, op_div, op_divu, op_rem, op_remu, op_ok, op_sgn;
    logic [WIDTH-1:0] a_eff, b_eff, a_abs, b_abs;
    logic             a_neg, b_neg, div_zero, ovf, special;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        op_mul  = (bus.op == 5'b00001);
        op_div  = (bus.op == 5'b00010);
        op_divu = (bus.op == 5'b00100);
        op_rem  = (bus.op == 5'b01000);
        op_remu = (bus.op == 5'b10000);
        op_ok   = op_mul | op_div | op_divu | op_rem | op_remu;
        op_sgn  = op_div | op_rem;

        a_eff = bus.src1;
        b_eff = bus.src2;
        if (bus.word && !op_mul) begin
            if (op_sgn) begin
                a_eff = {{(WIDTH-32){bus.src1[31]}}, bus.src1[31:0]};
                b_eff = {{(WIDTH-32){bus.src2[31]}}, bus.src2[31:0]};
            end else begin
                a_eff = {{(WIDTH-32){1'b0}}, bus.src1[31:0]};
                b_eff = {{(WIDTH-32){1'b0}}, bus.src2[31:0]};
            end
        end

        a_neg = op_sgn & a_eff[WIDTH-1];
        b_neg = op_sgn & b_eff[WIDTH-1];
        a_abs = a_neg ? -a_eff : a_eff;
        b_abs = b_neg ? -b_eff : b_eff;

        div_zero = (b_eff == '0);
        ovf      = op_sgn && (b_eff == '1) && (a_eff == (bus.word ? MinNegW : MinNeg));
        special  = !op_ok || (!op_mul && (div_zero || ovf));

        special_res = '0;
        if (op_ok && !op_mul) begin
            if (div_zero) begin
                special_res = (op_div | op_divu) ? '1 : a_eff;
            end else if (ovf) begin
                special_res = op_div ? a_eff : '0;
            end
        end
    end

    // Per-cycle iteration datapath
    logic             last;
    logic [WIDTH:0]   shifted, trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem, div_quo, div_fix;

    always_comb begin
        last    = (cnt_q == (word_q ? 6'd31 : 6'd63));
        shifted = {acc_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        // Remainder stays below the divisor, so a set top bit means a borrow.
        div_ok  = !trial[WIDTH];
        div_rem = div_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        div_quo = {quo_q[WIDTH-2:0], div_ok};
        if (rem_sel_q) begin
            div_fix = rneg_q ? -div_rem : div_rem;
        end else begin
            div_fix = qneg_q ? -div_quo : div_quo;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [WIDTH-1:0] fast_prod;
    assign fast_prod = bus.src1 * bus.src2;
`else
    logic [WIDTH-1:0] mul_acc;
    assign mul_acc = quo_q[0] ? (acc_q + dvs_q) : acc_q;
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        word_d    = word_q;
        rem_sel_d = rem_sel_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid && !bus.flush) begin
                    word_d = bus.word;
                    cnt_d  = '0;
                    if (special) begin
                        result_d = fmt_res(bus.word, special_res);
                        state_d  = StDone;
                    end else if (op_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        result_d = fmt_res(bus.word, fast_prod);
                        state_d  = StDone;
`else
                        acc_d   = '0;
                        dvs_d   = bus.src1;
                        quo_d   = bus.src2;
                        state_d = StMul;
`endif
                    end else begin
                        acc_d     = '0;
                        dvs_d     = b_abs;
                        // Word dividends sit in the top half so 32 shifts consume them.
                        quo_d     = bus.word ? {a_abs[31:0], 32'b0} : a_abs;
                        rem_sel_d = op_rem | op_remu;
                        qneg_d    = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        state_d   = StDiv;
                    end
                end
            end
`ifndef MULDIV_FAST_MUL_EN
            StMul: begin
                acc_d = mul_acc;
                dvs_d = dvs_q << 1;
                quo_d = quo_q >> 1;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    result_d = fmt_res(word_q, mul_acc);
                    state_d  = StDone;
                end
            end
`endif
            StDiv: begin
                acc_d = div_rem;
                quo_d = div_quo;
                cnt_d = cnt_q + 6'd1;
                if (last) begin
                    result_d = fmt_res(word_q, div_fix);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over everything; an aborted op never publishes a result.
        if (bus.flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            word_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            word_q    <= word_d;
            rem_sel_q <= rem_sel_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !bus.flush;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: reset state, signed/unsigned divide and
// remainder, word forms, special cases, multiply, backpressure, flush and
// mid-operation reset, each against hand-computed values.
module tb_muldiv_seq;

    localparam logic [4:0] OpMul  = 5'b00001;
    localparam logic [4:0] OpDiv  = 5'b00010;
    localparam logic [4:0] OpDivu = 5'b00100;
    localparam logic [4:0] OpRem  = 5'b01000;
    localparam logic [4:0] OpRemu = 5'b10000;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLat64 = 1;
    localparam int MulLat32 = 1;
`else
    localparam int MulLat64 = 65;
    localparam int MulLat32 = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    muldiv_seq_if #(.WIDTH(64)) bus ();

    muldiv_seq #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [4:0] o, input logic w, input logic [63:0] a,
                            input logic [63:0] b);
        @(negedge clk);
        bus.op       = o;
        bus.word     = w;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the request after the accept edge; the DUT must have captured it.
        bus.in_valid = 1'b0;
        bus.op       = OpMul;
        bus.word     = ~w;
        bus.src1     = ~a;
        bus.src2     = b + 64'd5;
    endtask

    // lat counts cycles from the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [4:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
        int lat;
        start_op(o, w, a, b);
        wait_done(lat);
        check_eq({tag, "_res"}, bus.result, exp);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        consume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.word      = 1'b0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_result", bus.result, 64'd0);
        rst = 1'b1;

        do_op("div_m7_2", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 65);
        do_op("rem_m7_2", OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 65);
        do_op("rem_by0", OpRem, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        do_op("divu_by0", OpDivu, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("div_ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1);
        do_op("rem_ovf", OpRem, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, 1);
        do_op("divw_ovf", OpDiv, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1);
        do_op("mulw", OpMul, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFE, MulLat32);
        do_op("mul64", OpMul, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
              64'hFFFF_FFFF_FFFF_FFFD, MulLat64);
        do_op("divuw", OpDivu, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd2,
              64'h0000_0000_7FFF_FFFF, 33);
        do_op("remuw", OpRemu, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 33);
        do_op("remw_m7_2", OpRem, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFF, 33);
        do_op("bad_op", 5'b00011, 1'b0, 64'd9, 64'd3, 64'd0, 1);

        // Backpressure: result must hold while out_ready stays low.
        start_op(OpDivu, 1'b0, 64'd100, 64'd7);
        wait_done(lat);
        check_eq("bp_lat", 64'(lat), 64'd65);
        check_eq("bp_res", bus.result, 64'd14);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_res", bus.result, 64'd14);
            check_eq("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
            check_eq("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
        end
        consume();
        check_eq("bp_after_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("bp_after_out_valid", 64'(bus.out_valid), 64'd0);
        do_op("bp_next_remu", OpRemu, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        // Flush ten iterations into a divide.
        start_op(OpDiv, 1'b0, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_eq("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        check_eq("flush_no_result", 64'(seen), 64'd0);
        do_op("post_flush_divu", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65);

        // Flush together with a request in IDLE: nothing is accepted.
        @(negedge clk);
        bus.op       = OpDivu;
        bus.word     = 1'b0;
        bus.src1     = 64'd100;
        bus.src2     = 64'd7;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        check_eq("flush_noacc_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("flush_noacc_out_valid", 64'(bus.out_valid), 64'd0);

        // Reset mid-operation returns everything to reset values.
        start_op(OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op("post_rst_div", OpDiv, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
              64'hFFFF_FFFF_FFFF_FFF2, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
